// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the toy processor. It watches the rd/wr strobes
// issued by the CPU control FSM, detects their rising edges, latches the
// address (and write data), waits WAIT_STATES extra cycles, performs the access
// on an internal word array, and reports completion with one-cycle pulses.
//
// Parameters
//   ADDR_W       address width, array depth is 2**ADDR_W words
//   DATA_W       data word width
//   WAIT_STATES  extra cycles between strobe detection and completion (0..15)
//
// Ports
//   clk     in   system clock, all state updates on posedge
//   rst     in   synchronous reset, active-high
//   rd      in   read strobe (level)
//   wr      in   write strobe (level)
//   addr    in   word address, sampled on strobe detection
//   wdata   in   write data, sampled on wr detection
//   rdata   out  last completed read value
//   rvalid  out  one-cycle pulse: read complete, rdata updated this cycle
//   wack    out  one-cycle pulse: write committed
//   busy    out  access (or memory clear) in progress
//   err     out  sticky protocol-error flag, cleared only by rst
//
// Optional feature (macro MEM_CLEAR_ON_RESET_EN): after rst deasserts the
// array is zeroed one word per cycle in a CLEAR state (busy held high, strobe
// rises flagged as errors). Without the macro the array persists across rst.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              busy,
  output logic              err
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

  state_t              state_q;
  logic                rd_q, wr_q;
  logic                op_wr_q;     // 1 = write access, 0 = read access
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q, wack_q, busy_q, err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                rd_rise, wr_rise;
  logic                start_d;
  logic                strobe_err_d;
  logic [ADDR_W-1:0]   raddr_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                clear_active;
  logic                clear_pending;

`ifdef MEM_CLEAR_ON_RESET_EN
  logic                clr_pend_q;  // set by rst, launches CLEAR on the first cycle out of reset
  logic [ADDR_W-1:0]   clr_addr_q;

  assign clear_active  = (state_q == S_CLEAR);
  assign clear_pending = clr_pend_q;
`else
  assign clear_active  = 1'b0;
  assign clear_pending = 1'b0;
`endif

  assign rd_rise = rd & ~rd_q;
  assign wr_rise = wr & ~wr_q;

  // Exactly one strobe rising while idle starts an access.
  assign start_d = (state_q == S_IDLE) & ~clear_pending & (rd_rise ^ wr_rise);

  // Simultaneous rises, or any rise while occupied, are protocol errors.
  assign strobe_err_d = (rd_rise & wr_rise) |
                        ((rd_rise | wr_rise) & ((state_q != S_IDLE) | clear_pending));

  // Single read port: with zero wait states the read happens on the same edge
  // that detects the strobe, so the live address is used instead of the latch.
  assign raddr_d = (state_q == S_IDLE) ? addr : addr_q;

  // Single write port shared by normal writes and the clear sweep. A write is
  // suppressed whenever rst is high, which aborts an access caught in DONE.
  assign mem_we_d    = ~rst & (((state_q == S_DONE) & op_wr_q) | clear_active);
  assign mem_waddr_d = clear_active ? clr_addr_q_or_zero() : addr_q;
  assign mem_wdata_d = clear_active ? '0 : wdata_q;

  function automatic logic [ADDR_W-1:0] clr_addr_q_or_zero();
`ifdef MEM_CLEAR_ON_RESET_EN
    return clr_addr_q;
`else
    return '0;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
      clr_pend_q <= 1'b1;
      clr_addr_q <= '0;
`endif
    end else begin
      rd_q     <= rd;
      wr_q     <= wr;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      if (strobe_err_d) begin
        err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
`ifdef MEM_CLEAR_ON_RESET_EN
          if (clr_pend_q) begin
            clr_pend_q <= 1'b0;
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
          end else
`endif
          if (start_d) begin
            addr_q  <= addr;
            op_wr_q <= wr_rise;
            if (wr_rise) begin
              wdata_q <= wdata;
            end
            cnt_q  <= WS_INIT;
            busy_q <= 1'b1;
            if (WAIT_STATES == 0) begin
              // Completion pulse lands in the very next cycle.
              state_q <= S_DONE;
              if (rd_rise) begin
                rdata_q  <= mem_q[raddr_d];
                rvalid_q <= 1'b1;
              end else begin
                wack_q <= 1'b1;
              end
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // Outputs are registered, so the pulse is launched on the edge
            // entering DONE and is visible for the whole DONE cycle.
            state_q <= S_DONE;
            if (op_wr_q) begin
              wack_q <= 1'b1;
            end else begin
              rdata_q  <= mem_q[raddr_d];
              rvalid_q <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

`ifdef MEM_CLEAR_ON_RESET_EN
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR_W{1'b1}}) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wack   = wack_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with default WAIT_STATES=1
  logic       rd1 = 1'b0, wr1 = 1'b0;
  logic [4:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic [7:0] rdata1;
  logic       rvalid1, wack1, busy1, err1;

  // Instance with WAIT_STATES=0
  logic       rd0 = 1'b0, wr0 = 1'b0;
  logic [4:0] addr0 = '0;
  logic [7:0] wdata0 = '0;
  logic [7:0] rdata0;
  logic       rvalid0, wack0, busy0, err0;

  // Instance with WAIT_STATES=3
  logic       rd3 = 1'b0, wr3 = 1'b0;
  logic [4:0] addr3 = '0;
  logic [7:0] wdata3 = '0;
  logic [7:0] rdata3;
  logic       rvalid3, wack3, busy3, err3;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst), .rd(rd1), .wr(wr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .rvalid(rvalid1), .wack(wack1), .busy(busy1), .err(err1)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .rd(rd0), .wr(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .rvalid(rvalid0), .wack(wack0), .busy(busy0), .err(err0)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .rd(rd3), .wr(wr3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .rvalid(rvalid3), .wack(wack3), .busy(busy3), .err(err3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset all instances; with the clear feature, wait out the clear sweep.
  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
    repeat (40) next_cycle();
`endif
  endtask

  // One table row: inputs for a cycle, and outputs expected in that same
  // cycle (they reflect the inputs of the previous row).
  typedef struct packed {
    logic       rst;
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic       rvalid;
    logic       wack;
    logic       busy;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic d, input logic w,
                              input logic [4:0] a, input logic [7:0] wd,
                              input logic c, input logic rv, input logic wk,
                              input logic bz, input logic er, input logic [7:0] rdt);
    vec_t v;
    v.rst = r; v.rd = d; v.wr = w; v.addr = a; v.wdata = wd;
    v.chk = c; v.rvalid = rv; v.wack = wk; v.busy = bz; v.err = er; v.rdata = rdt;
    return v;
  endfunction

  initial begin
    int busy_cnt;

    //               rst rd wr addr  wdata  chk rv wk bz er rdata
    vecs[0]  = mk(1, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    vecs[2]  = mk(0, 0, 1, 5'd5, 8'hA5, 1, 0, 0, 0, 0, 8'h00); // write 5 <- A5
    vecs[3]  = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 0, 8'h00); // WAIT
    vecs[4]  = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 1, 1, 0, 8'h00); // DONE, wack
    vecs[5]  = mk(0, 1, 0, 5'd5, 8'h00, 1, 0, 0, 0, 0, 8'h00); // read 5, held
    vecs[6]  = mk(0, 1, 0, 5'd5, 8'h00, 1, 0, 0, 1, 0, 8'h00);
    vecs[7]  = mk(0, 1, 0, 5'd5, 8'h00, 1, 1, 0, 1, 0, 8'hA5); // rvalid
    vecs[8]  = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 0, 8'hA5); // rdata holds
    vecs[9]  = mk(0, 0, 1, 5'd7, 8'h11, 1, 0, 0, 0, 0, 8'hA5); // write 7 <- 11
    vecs[10] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 0, 8'hA5);
    vecs[11] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 1, 1, 0, 8'hA5);
    vecs[12] = mk(0, 1, 1, 5'd7, 8'h99, 1, 0, 0, 0, 0, 8'hA5); // rd+wr together
    vecs[13] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 1, 8'hA5); // err, no access
    vecs[14] = mk(0, 1, 0, 5'd7, 8'h00, 1, 0, 0, 0, 1, 8'hA5); // read 7
    vecs[15] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 1, 8'hA5);
    vecs[16] = mk(0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 1, 1, 8'h11); // unchanged
    vecs[17] = mk(1, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 1, 8'h11); // rst
    vecs[18] = mk(0, 0, 1, 5'd7, 8'h3C, 1, 0, 0, 0, 0, 8'h00); // write 7 <- 3C
    vecs[19] = mk(1, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 0, 8'h00); // rst in WAIT
    vecs[20] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 0, 8'h00); // aborted
    vecs[21] = mk(0, 1, 0, 5'd7, 8'h00, 1, 0, 0, 0, 0, 8'h00); // read 7
    vecs[22] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
    vecs[23] = mk(0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 1, 0, 8'h11); // still 11
    vecs[24] = mk(0, 0, 1, 5'd3, 8'h42, 1, 0, 0, 0, 0, 8'h11); // write 3 <- 42
    vecs[25] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 0, 8'h11);
    vecs[26] = mk(0, 1, 0, 5'd3, 8'h00, 1, 0, 1, 1, 0, 8'h11); // rd rise in DONE
    vecs[27] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 1, 8'h11); // ignored, err
    vecs[28] = mk(0, 1, 0, 5'd3, 8'h00, 1, 0, 0, 0, 1, 8'h11); // read 3
    vecs[29] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 1, 1, 8'h11);
    vecs[30] = mk(0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 1, 1, 8'h42); // new data
    vecs[31] = mk(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 1, 8'h42);

`ifndef MEM_CLEAR_ON_RESET_EN
    // ---------------- table-driven run on WAIT_STATES=1 ----------------
    for (int k = 0; k < NV; k++) begin
      next_cycle();
      rst    = vecs[k].rst;
      rd1    = vecs[k].rd;
      wr1    = vecs[k].wr;
      addr1  = vecs[k].addr;
      wdata1 = vecs[k].wdata;
      @(negedge clk);
      if (vecs[k].chk) begin
        check($sformatf("ws1_row%0d {rvalid,wack,busy,err,rdata}", k),
              32'({rvalid1, wack1, busy1, err1, rdata1}),
              32'({vecs[k].rvalid, vecs[k].wack, vecs[k].busy, vecs[k].err, vecs[k].rdata}));
      end
    end
`else
    // ---------------- memory clear on reset (WAIT_STATES=1) ----------------
    do_reset();
    check("clr_idle_after_reset busy", 32'(busy1), 32'd0);
    wr1 = 1'b1; addr1 = 5'd31; wdata1 = 8'hFF;
    next_cycle();
    wr1 = 1'b0;
    next_cycle();
    @(negedge clk);
    check("clr_preload wack", 32'(wack1), 32'd1);
    next_cycle();
    rd1 = 1'b1;
    next_cycle();
    rd1 = 1'b0;
    next_cycle();
    @(negedge clk);
    check("clr_preload read {rvalid,rdata}", 32'({rvalid1, rdata1}), 32'h1FF);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy1) busy_cnt++;
      next_cycle();
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    rd1 = 1'b1; addr1 = 5'd31;
    next_cycle();
    rd1 = 1'b0;
    next_cycle();
    @(negedge clk);
    check("clr_read31 {rvalid,rdata}", 32'({rvalid1, rdata1}), 32'h100);
`endif

    // ---------------- WAIT_STATES=0: held rd, single response ----------------
    do_reset();
    wr0 = 1'b1; addr0 = 5'd2; wdata0 = 8'h5A;
    next_cycle();
    wr0 = 1'b0;
    @(negedge clk);
    check("ws0_write {wack,busy}", 32'({wack0, busy0}), 32'h3);
    next_cycle();
    rd0 = 1'b1; addr0 = 5'd2;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      if (c == 4) rd0 = 1'b0;
      @(negedge clk);
      check($sformatf("ws0_held_rd c%0d rvalid", c), 32'(rvalid0), (c == 1) ? 32'd1 : 32'd0);
      if (c == 1) check("ws0_held_rd rdata", 32'(rdata0), 32'h5A);
    end

    // ---------------- WAIT_STATES=3: second rise during WAIT ----------------
    do_reset();
    wr3 = 1'b1; addr3 = 5'd4; wdata3 = 8'h77;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) wr3 = 1'b0;
      @(negedge clk);
      check($sformatf("ws3_write c%0d wack", c), 32'(wack3), (c == 4) ? 32'd1 : 32'd0);
    end
    next_cycle();
    rd3 = 1'b1; addr3 = 5'd4;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) rd3 = 1'b0;
      if (c == 2) begin rd3 = 1'b1; addr3 = 5'd9; end
      if (c == 3) rd3 = 1'b0;
      @(negedge clk);
      check($sformatf("ws3_rd c%0d {rvalid,err}", c), 32'({rvalid3, err3}),
            32'({(c == 4), (c >= 3)}));
      if (c == 4) check("ws3_rd rdata", 32'(rdata3), 32'h77);
    end
    repeat (5) next_cycle();
    @(negedge clk);
    check("ws3_err_sticky", 32'(err3), 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("ws3_err_cleared_by_rst", 32'(err3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder to the rd/wr strobes that the CPU control state machine issues.
- Detects strobe rising edges, latches address and write data, and inserts a configurable number of wait states.
- Performs the access on an internal memory array, then reports completion with single-cycle pulses.
- Sits between the controller/address mux and the data bus in the toy processor.

Parameters:
- ADDR_W, 5, address width; memory depth is 2**ADDR_W words.
- DATA_W, 8, data word width.
- WAIT_STATES, 1, number of extra cycles between strobe detection and completion; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- rd  input  1  read strobe from controller; level signal, may be held for several cycles.
- wr  input  1  write strobe from controller; level signal.
- addr  input  ADDR_W  word address; sampled only at strobe detection.
- wdata  input  DATA_W  write data; sampled only at wr detection.
- rdata  output  DATA_W  read data; holds last completed read value.
- rvalid  output  1  one-cycle pulse: read complete, rdata updated this cycle.
- wack  output  1  one-cycle pulse: write committed to array.
- busy  output  1  high while an access (or memory clear) is in progress.
- err  output  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at posedge):
  - rdata=0, rvalid=0, wack=0, busy=0, err=0.
  - FSM goes to IDLE; rd_q=0 and wr_q=0 (previous-cycle strobe registers).
  - Any in-flight access is aborted: no array write and no rvalid/wack pulse.
- Edge detect: rd_rise = rd & ~rd_q; wr_rise = wr & ~wr_q. rd_q and wr_q update every cycle, in all states.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - rd_rise & ~wr_rise: latch addr, op=READ, cnt=WAIT_STATES. Go to DONE if WAIT_STATES=0, else WAIT.
    - wr_rise & ~rd_rise: latch addr and wdata, op=WRITE, same transition rule.
    - rd_rise & wr_rise in the same cycle: err<=1, no access, stay IDLE.
  - WAIT: cnt decrements each cycle; when cnt==1, go to DONE.
  - DONE (one cycle), then IDLE:
    - READ: rdata<=mem[addr_lat] and rvalid=1 in this cycle.
    - WRITE: mem[addr_lat]<=wdata_lat at the edge ending this cycle, and wack=1 in this cycle.
- Latency: strobe rise visible in cycle N gives the completion pulse in cycle N+1+WAIT_STATES.
- busy=1 in WAIT and DONE; busy=0 in IDLE.
- A strobe rise while not in IDLE is ignored (not queued) and sets err<=1.
- Strobe levels held high do not retrigger an access. A fresh access needs the strobe to drop and rise again.
- rvalid and wack are never high in the same cycle, and each is high for exactly one cycle per access.
- A strobe deasserting before DONE does not cancel the access.
- Read-after-write to the same address returns the new data once wack has pulsed.
- Address wraps naturally at 2**ADDR_W; no out-of-range condition exists.
- Memory contents are not affected by rst unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_CLEAR_ON_RESET_EN.
- When defined:
  - When rst deasserts, the FSM enters CLEAR and writes 0 to every word, one word per cycle, addresses 0 to 2**ADDR_W-1.
  - busy=1 throughout CLEAR.
  - Strobe rises during CLEAR set err and are ignored.
  - Return to IDLE after the last word is written (2**ADDR_W cycles).
  - rst asserted during CLEAR restarts the clear from address 0.
- When undefined: CLEAR does not exist, IDLE is entered directly after reset, and array contents persist across rst.

Test Plan:
- WAIT_STATES=1: wr pulse, addr=5, wdata=8'hA5, rise in cycle N. Required: wack=1 in cycle N+2 only, busy=1 in N+1..N+2. Then rd rise at addr=5: rvalid one cycle with rdata=8'hA5, and rdata holds A5 afterward.
- WAIT_STATES=0: rd held high 4 cycles. Required: exactly one rvalid, in cycle N+1, and no retrigger while rd stays high.
- rd and wr rise in the same cycle. Required: err=1 from the next cycle, no wack or rvalid, memory unchanged (verified by a later read), err stays 1 until rst.
- Second rd rise during WAIT (WAIT_STATES=3). Required: err=1, only the first access completes, at cycle N+4.
- rst asserted in WAIT of a write to addr=7 with data 8'h3C. Required: all outputs 0 next cycle, no wack. A subsequent read of addr 7 returns the prior contents, not 8'h3C.
- With MEM_CLEAR_ON_RESET_EN and ADDR_W=5: preload addr=31 with 8'hFF, then assert rst. Required: busy=1 for 32 cycles after rst deasserts, and a read of addr 31 then returns 8'h00.
